// File: rtl/dram_dq_responder.sv
// -----------------------------------------------------------------------------
// dram_dq_responder
//
// Device-side end of the DRAM data bus. A read command drives a BL-beat burst
// onto DQ, with a source-synchronous DQS pair, RL cycles after the command is
// accepted. A write command captures a BL-beat burst from DQ/DM_n WL cycles
// after it is accepted. The captured words and their masks go to the memory
// array as one line. Each tri-state pin is split into in/out/oe, and the
// enclosing level resolves the wires.
//
// Ports
//   CLK, RST              clock, synchronous active-high reset
//   cmd_valid/cmd_ready   command handshake; accepted when both are high
//   cmd_write, cmd_col    burst direction and starting beat (column)
//   rd_line               array line for reads; word i = [i*WORD_W +: WORD_W]
//   wr_line, wr_mask      captured write line, per-word write enable
//   wr_done               one-cycle pulse: wr_line/wr_mask valid
//   dq_in/dq_out/dq_oe    data bus
//   dqs_{t,c}_{in,out}    strobe pair, dqs_oe enables the driven pair
//   dm_n_in               data mask, active low (0 = beat masked)
//   strobe_err            sticky: a write beat arrived with dqs_t == dqs_c
// -----------------------------------------------------------------------------
module dram_dq_responder #(
  parameter int WORD_W = 32,
  parameter int BL     = 8,
  parameter int RL     = 4,
  parameter int WL     = 2
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      cmd_valid,
  input  logic                      cmd_write,
  input  logic [$clog2(BL)-1:0]     cmd_col,
  output logic                      cmd_ready,
  input  logic [BL*WORD_W-1:0]      rd_line,
  output logic [BL*WORD_W-1:0]      wr_line,
  output logic [BL-1:0]             wr_mask,
  output logic                      wr_done,
  input  logic [WORD_W-1:0]         dq_in,
  output logic [WORD_W-1:0]         dq_out,
  output logic                      dq_oe,
  input  logic                      dqs_t_in,
  input  logic                      dqs_c_in,
  output logic                      dqs_t_out,
  output logic                      dqs_c_out,
  output logic                      dqs_oe,
  input  logic                      dm_n_in,
  output logic                      strobe_err
);

  localparam int COL_W = $clog2(BL);
  localparam int CNT_W = $clog2(RL + WL) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_PRE,
    S_BURST,
    S_POST,
    S_DONE
  } state_t;

  state_t             state, state_nxt;
  logic               is_wr;
  logic [COL_W-1:0]   col;
  logic [COL_W-1:0]   beat;
  logic [COL_W-1:0]   idx;
  logic [CNT_W-1:0]   wait_cnt;
  logic [WORD_W-1:0]  rd_words [BL];
  logic [WORD_W-1:0]  wr_words [BL];
  logic [BL-1:0]      wr_mask_q;
  logic               strobe_err_q;
  logic               accept;

  assign accept = cmd_valid && (state == S_IDLE);

  // The column is log2(BL) bits wide, so this sum wraps modulo BL.
  assign idx = col + beat;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: every clocked block uses non-blocking assignments so that all
  // registers update together from values sampled before the clock edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and outputs
  // ---------------------------------------------------------------------------
  // NOTE: every output of this block gets a default before the case
  // statement, so no path through it leaves a value unassigned and no latch
  // is inferred.
  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    dq_oe     = 1'b0;
    dq_out    = '0;
    dqs_oe    = 1'b0;
    dqs_t_out = 1'b0;
    dqs_c_out = 1'b1;
    wr_done   = 1'b0;

    case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (accept) begin
          // WAIT lasts RL-2 cycles for reads and WL-1 cycles for writes. It
          // is skipped entirely when that count is zero.
          if (cmd_write) begin
            state_nxt = (WL > 1) ? S_WAIT : S_BURST;
          end else begin
            state_nxt = (RL > 2) ? S_WAIT : S_PRE;
          end
        end
      end
      S_WAIT: begin
        if (wait_cnt == '0) begin
          state_nxt = is_wr ? S_BURST : S_PRE;
        end
      end
      S_PRE: begin
        // Read preamble: drive the strobe low for one cycle before data.
        dqs_oe    = 1'b1;
        state_nxt = S_BURST;
      end
      S_BURST: begin
        if (!is_wr) begin
          dq_oe     = 1'b1;
          dq_out    = rd_words[idx];
          dqs_oe    = 1'b1;
          dqs_t_out = ~beat[0];
          dqs_c_out = beat[0];
        end
        if (beat == COL_W'(BL - 1)) begin
          state_nxt = is_wr ? S_DONE : S_POST;
        end
      end
      S_POST: begin
        // Read postamble: hold the strobe low for one cycle after data.
        dqs_oe    = 1'b1;
        state_nxt = S_IDLE;
      end
      S_DONE: begin
        wr_done   = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Command latch, beat counters, and write capture
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      is_wr        <= 1'b0;
      col          <= '0;
      beat         <= '0;
      wait_cnt     <= '0;
      wr_mask_q    <= '0;
      strobe_err_q <= 1'b0;
      for (int i = 0; i < BL; i++) begin
        wr_words[i] <= '0;
      end
    end else begin
      if (accept) begin
        is_wr    <= cmd_write;
        col      <= cmd_col;
        beat     <= '0;
        // Load WAIT length minus one. The value is unused when WAIT is
        // skipped.
        wait_cnt <= cmd_write ? CNT_W'(WL - 2) : CNT_W'(RL - 3);
        if (cmd_write) begin
          wr_mask_q <= '0;
        end
      end

      if (state == S_WAIT) begin
        wait_cnt <= wait_cnt - CNT_W'(1);
      end

      if (state == S_BURST) begin
        beat <= beat + COL_W'(1);
        if (is_wr) begin
          // Data is captured even on masked beats. The mask alone decides
          // whether the array word is written.
          wr_words[idx]  <= dq_in;
          wr_mask_q[idx] <= dm_n_in;
          if (dqs_t_in == dqs_c_in) begin
            strobe_err_q <= 1'b1;
          end
        end
      end
    end
  end

  // NOTE: the read line buffer is not reset. It is always loaded at accept
  // before any beat reads it, so a reset would only add fan-out.
  always_ff @(posedge CLK) begin
    if (accept && !cmd_write) begin
      for (int i = 0; i < BL; i++) begin
        rd_words[i] <= rd_line[i*WORD_W +: WORD_W];
      end
    end
  end

  for (genvar g = 0; g < BL; g++) begin : g_wr_line
    assign wr_line[g*WORD_W +: WORD_W] = wr_words[g];
  end

  assign wr_mask    = wr_mask_q;
  assign strobe_err = strobe_err_q;

endmodule

// File: tb/tb_dram_dq_responder.sv
// -----------------------------------------------------------------------------
// tb_dram_dq_responder
//
// Directed bench for dram_dq_responder. A timeline model holds the expected
// pin values for every cycle. Each issued command writes its effect into that
// timeline, and a compare process checks the DUT against it on every falling
// edge. Literal spot checks pin the model to hand-computed values.
// -----------------------------------------------------------------------------
module tb_dram_dq_responder;

  localparam int WORD_W = 32;
  localparam int BL     = 8;
  localparam int RL     = 4;
  localparam int WL     = 2;
  localparam int MAXC   = 300;

  logic                  CLK = 1'b0;
  logic                  RST;
  logic                  cmd_valid;
  logic                  cmd_write;
  logic [2:0]            cmd_col;
  logic                  cmd_ready;
  logic [BL*WORD_W-1:0]  rd_line;
  logic [BL*WORD_W-1:0]  wr_line;
  logic [BL-1:0]         wr_mask;
  logic                  wr_done;
  logic [WORD_W-1:0]     dq_in;
  logic [WORD_W-1:0]     dq_out;
  logic                  dq_oe;
  logic                  dqs_t_in, dqs_c_in;
  logic                  dqs_t_out, dqs_c_out;
  logic                  dqs_oe;
  logic                  dm_n_in;
  logic                  strobe_err;

  dram_dq_responder #(
    .WORD_W(WORD_W), .BL(BL), .RL(RL), .WL(WL)
  ) dut (
    .CLK(CLK), .RST(RST),
    .cmd_valid(cmd_valid), .cmd_write(cmd_write), .cmd_col(cmd_col),
    .cmd_ready(cmd_ready),
    .rd_line(rd_line), .wr_line(wr_line), .wr_mask(wr_mask), .wr_done(wr_done),
    .dq_in(dq_in), .dq_out(dq_out), .dq_oe(dq_oe),
    .dqs_t_in(dqs_t_in), .dqs_c_in(dqs_c_in),
    .dqs_t_out(dqs_t_out), .dqs_c_out(dqs_c_out), .dqs_oe(dqs_oe),
    .dm_n_in(dm_n_in), .strobe_err(strobe_err)
  );

  always #5 CLK = ~CLK;

  // Cycle n is the interval after rising edge n.
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [255:0] act,
                       input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Timeline model
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic        ready;
    logic        dq_oe;
    logic        dqs_oe;
    logic        dqs_t;
    logic        dqs_c;
    logic        wr_done;
    logic        serr;
    logic [31:0] dq;
  } exp_t;

  exp_t           em [MAXC];
  logic [255:0]   exp_line;
  logic [7:0]     exp_mask;

  function automatic exp_t idle_exp(input logic serr);
    exp_t e;
    e = '{ready: 1'b1, dq_oe: 1'b0, dqs_oe: 1'b0, dqs_t: 1'b0, dqs_c: 1'b1,
          wr_done: 1'b0, serr: serr, dq: 32'h0};
    return e;
  endfunction

  always @(negedge CLK) begin
    if (chk_en && cyc < MAXC) begin
      check($sformatf("c%0d cmd_ready", cyc), 256'(cmd_ready), 256'(em[cyc].ready));
      check($sformatf("c%0d dq_oe", cyc), 256'(dq_oe), 256'(em[cyc].dq_oe));
      check($sformatf("c%0d dqs_oe", cyc), 256'(dqs_oe), 256'(em[cyc].dqs_oe));
      check($sformatf("c%0d wr_done", cyc), 256'(wr_done), 256'(em[cyc].wr_done));
      check($sformatf("c%0d strobe_err", cyc), 256'(strobe_err), 256'(em[cyc].serr));
      if (em[cyc].dqs_oe) begin
        check($sformatf("c%0d dqs_t", cyc), 256'(dqs_t_out), 256'(em[cyc].dqs_t));
        check($sformatf("c%0d dqs_c", cyc), 256'(dqs_c_out), 256'(em[cyc].dqs_c));
      end
      if (em[cyc].dq_oe) begin
        check($sformatf("c%0d dq_out", cyc), 256'(dq_out), 256'(em[cyc].dq));
      end
      if (em[cyc].wr_done) begin
        check($sformatf("c%0d wr_line", cyc), wr_line, exp_line);
        check($sformatf("c%0d wr_mask", cyc), 256'(wr_mask), 256'(exp_mask));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic run_to(input int t);
    while (cyc < t) tick();
  endtask

  // Issues a read in the current cycle, which must be an idle cycle.
  task automatic read_cmd(input logic [2:0] col, input logic [255:0] line,
                          output int t0);
    int w;
    t0        = cyc;
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_col   = col;
    rd_line   = line;
    for (int i = 1; i <= RL + BL; i++) em[t0+i].ready = 1'b0;
    em[t0+RL-1].dqs_oe = 1'b1;
    em[t0+RL-1].dqs_t  = 1'b0;
    em[t0+RL-1].dqs_c  = 1'b1;
    for (int k = 0; k < BL; k++) begin
      w = (int'(col) + k) % BL;
      em[t0+RL+k].dq_oe  = 1'b1;
      em[t0+RL+k].dqs_oe = 1'b1;
      em[t0+RL+k].dq     = line[w*32 +: 32];
      em[t0+RL+k].dqs_t  = (k % 2 == 0);
      em[t0+RL+k].dqs_c  = (k % 2 != 0);
    end
    em[t0+RL+BL].dqs_oe = 1'b1;
    em[t0+RL+BL].dqs_t  = 1'b0;
    em[t0+RL+BL].dqs_c  = 1'b1;
    tick();
    cmd_valid = 1'b0;
    rd_line   = ~line;  // the burst must come from the copy taken at accept
  endtask

  // Issues a write and drives its beats. Returns in the DONE cycle.
  // Beat k carries data[k*32 +: 32] and dm_n = dmn[k].
  task automatic write_cmd(input logic [2:0] col, input logic [255:0] data,
                           input logic [7:0] dmn, input int bad_beat,
                           input bit poke, output int t0);
    int w;
    t0        = cyc;
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_col   = col;
    for (int i = 1; i <= WL + BL; i++) em[t0+i].ready = 1'b0;
    em[t0+WL+BL].wr_done = 1'b1;
    exp_mask = '0;
    for (int k = 0; k < BL; k++) begin
      w = (int'(col) + k) % BL;
      exp_line[w*32 +: 32] = data[k*32 +: 32];
      exp_mask[w]          = dmn[k];
    end
    if (bad_beat >= 0) begin
      for (int i = t0 + WL + bad_beat + 1; i < MAXC; i++) em[i].serr = 1'b1;
    end
    tick();
    cmd_valid = poke;      // a read request during the burst must be ignored
    cmd_write = 1'b0;
    run_to(t0 + WL);
    for (int k = 0; k < BL; k++) begin
      dq_in    = data[k*32 +: 32];
      dm_n_in  = dmn[k];
      dqs_t_in = (k % 2 == 0);
      dqs_c_in = (k % 2 != 0);
      if (k == bad_beat) begin
        dqs_t_in = 1'b1;
        dqs_c_in = 1'b1;
      end
      tick();
    end
    cmd_valid = 1'b0;
    dq_in     = '0;
    dm_n_in   = 1'b1;
    dqs_t_in  = 1'b0;
    dqs_c_in  = 1'b1;
  endtask

  function automatic logic [255:0] make_line(input logic [31:0] base);
    logic [255:0] l;
    for (int i = 0; i < BL; i++) l[i*32 +: 32] = base + 32'(i);
    return l;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    int t0;
    logic [255:0] l;

    for (int i = 0; i < MAXC; i++) em[i] = idle_exp(1'b0);
    exp_line  = '0;
    exp_mask  = '0;
    RST       = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_col   = '0;
    rd_line   = '0;
    dq_in     = '0;
    dm_n_in   = 1'b1;
    dqs_t_in  = 1'b0;
    dqs_c_in  = 1'b1;

    tick();
    tick();
    RST = 1'b0;
    check("rst cmd_ready", 256'(cmd_ready), 256'(1));
    check("rst dq_oe", 256'(dq_oe), 256'(0));
    check("rst dqs_oe", 256'(dqs_oe), 256'(0));
    check("rst dqs_t", 256'(dqs_t_out), 256'(0));
    check("rst dqs_c", 256'(dqs_c_out), 256'(1));
    check("rst dq_out", 256'(dq_out), 256'(0));
    check("rst wr_done", 256'(wr_done), 256'(0));
    check("rst wr_mask", 256'(wr_mask), 256'(0));
    check("rst strobe_err", 256'(strobe_err), 256'(0));
    chk_en = 1'b1;

    // Read at column 0.
    read_cmd(3'd0, make_line(32'h100), t0);
    run_to(t0 + 3);
    check("rd0 pre dqs_oe", 256'(dqs_oe), 256'(1));
    check("rd0 pre dqs_t", 256'(dqs_t_out), 256'(0));
    check("rd0 pre dq_oe", 256'(dq_oe), 256'(0));
    run_to(t0 + 4);
    check("rd0 beat0 dq", 256'(dq_out), 256'(32'h100));
    check("rd0 beat0 dqs_t", 256'(dqs_t_out), 256'(1));
    run_to(t0 + 11);
    check("rd0 beat7 dq", 256'(dq_out), 256'(32'h107));
    check("rd0 beat7 dqs_t", 256'(dqs_t_out), 256'(0));
    run_to(t0 + 12);
    check("rd0 post dq_oe", 256'(dq_oe), 256'(0));
    check("rd0 post dqs_oe", 256'(dqs_oe), 256'(1));
    run_to(t0 + 13);
    check("rd0 idle ready", 256'(cmd_ready), 256'(1));

    // Back-to-back read with wrap-around from column 5.
    read_cmd(3'd5, make_line(32'h100), t0);
    run_to(t0 + 4);
    check("rd5 beat0 dq", 256'(dq_out), 256'(32'h105));
    run_to(t0 + 7);
    check("rd5 beat3 dq", 256'(dq_out), 256'(32'h100));
    run_to(t0 + 11);
    check("rd5 beat7 dq", 256'(dq_out), 256'(32'h104));
    run_to(t0 + 13);

    // Write at column 2, beat 3 masked (lands in word 5).
    write_cmd(3'd2, make_line(32'hA0), 8'b1111_0111, -1, 1'b0, t0);
    check("wr2 done cycle", 256'(cyc - t0), 256'(10));
    check("wr2 wr_done", 256'(wr_done), 256'(1));
    check("wr2 wr_mask", 256'(wr_mask), 256'(8'hDF));
    l = wr_line;
    check("wr2 word2", 256'(l[2*32 +: 32]), 256'(32'hA0));
    check("wr2 word5", 256'(l[5*32 +: 32]), 256'(32'hA3));
    check("wr2 word1", 256'(l[1*32 +: 32]), 256'(32'hA7));
    check("wr2 strobe_err", 256'(strobe_err), 256'(0));
    tick();
    check("wr2 mask hold", 256'(wr_mask), 256'(8'hDF));

    // Write with an illegal strobe on beat 4 and a read request mid-burst.
    write_cmd(3'd7, make_line(32'hB0), 8'hFF, 4, 1'b1, t0);
    run_to(t0 + WL + BL + 1);
    check("wr7 strobe_err", 256'(strobe_err), 256'(1));
    read_cmd(3'd3, make_line(32'h300), t0);
    run_to(t0 + RL + BL + 1);
    check("rd3 strobe_err sticky", 256'(strobe_err), 256'(1));

    // Reset in the middle of a read burst.
    read_cmd(3'd1, make_line(32'h400), t0);
    run_to(t0 + 6);
    RST = 1'b1;
    for (int i = t0 + 7; i < MAXC; i++) em[i] = idle_exp(1'b0);
    tick();
    RST = 1'b0;
    check("abort dq_oe", 256'(dq_oe), 256'(0));
    check("abort dqs_oe", 256'(dqs_oe), 256'(0));
    check("abort ready", 256'(cmd_ready), 256'(1));
    check("abort wr_mask", 256'(wr_mask), 256'(0));
    check("abort strobe_err", 256'(strobe_err), 256'(0));

    // A write after the abort completes normally; beats 0 and 7 masked.
    write_cmd(3'd0, make_line(32'hC0), 8'b0111_1110, -1, 1'b0, t0);
    check("wr0 wr_done", 256'(wr_done), 256'(1));
    check("wr0 wr_mask", 256'(wr_mask), 256'(8'h7E));
    l = wr_line;
    check("wr0 word7", 256'(l[7*32 +: 32]), 256'(32'hC7));
    run_to(t0 + WL + BL + 4);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dram_dq_responder.md
Name: dram_dq_responder

Overview:
Device-side end of the DRAM data bus: the DRAM-model counterpart to the controller's data-transfer block. On a read command it drives a BL-beat burst onto DQ with source-synchronous DQS after read latency. On a write command it captures a burst from DQ/DM_n after write latency and hands a masked line to the memory array. Tri-states are split into in/out/oe; the top level resolves the wires.

Parameters:
WORD_W, 32, DQ width per beat (matches dram_pkg WORD_W)
BL, 8, burst length in beats, power of two; column select is log2(BL) bits
RL, 4, read latency in CLK cycles from command accept to first driven beat; must be >= 2
WL, 2, write latency in CLK cycles from command accept to first captured beat; must be >= 1

Ports:
CLK  input  1  clock
RST  input  1  synchronous active-high reset
cmd_valid  input  1  command request
cmd_write  input  1  1 = write burst, 0 = read burst
cmd_col  input  log2(BL)  starting beat (COL_choice)
cmd_ready  output  1  responder idle, command accepted when valid&ready
rd_line  input  BL*WORD_W  array data for reads; word i = bits [i*WORD_W +: WORD_W]
wr_line  output  BL*WORD_W  captured write data, word-indexed like rd_line
wr_mask  output  BL  per-word write enable (1 = write)
wr_done  output  1  one-cycle pulse: wr_line/wr_mask valid
dq_in  input  WORD_W  sampled DQ
dq_out  output  WORD_W  driven DQ
dq_oe  output  1  DQ output enable
dqs_t_in, dqs_c_in  input  1 each  sampled strobe pair
dqs_t_out, dqs_c_out  output  1 each  driven strobe pair
dqs_oe  output  1  strobe output enable
dm_n_in  input  1  data mask, active low (0 = beat masked)
strobe_err  output  1  sticky: write beat seen with dqs_t_in == dqs_c_in

Behaviour:
- Reset: state IDLE; cmd_ready=1; dq_oe=dqs_oe=0; dq_out=0; dqs_t_out=0, dqs_c_out=1; wr_line=0; wr_mask=0; wr_done=0; strobe_err=0. RST mid-burst aborts: all oe low the next cycle, no wr_done, partial capture discarded (wr_mask cleared).
- States: IDLE, WAIT, PRE, BURST, POST, DONE. cmd_ready=1 only in IDLE; cmd_valid ignored elsewhere.
- Accept at cycle T0: latch cmd_write, cmd_col, and (for reads) rd_line.
- Beat order: beat k (k=0..BL-1) uses word index (cmd_col + k) mod BL, wrap-around.
- Read: WAIT through T0+RL-2. PRE at T0+RL-1: dqs_oe=1, dqs_t_out=0, dqs_c_out=1, dq_oe=0. BURST T0+RL .. T0+RL+BL-1: dq_oe=1, dq_out=word[(col+k) mod BL], dqs_t_out=1 on even k, 0 on odd k, dqs_c_out=~dqs_t_out. POST at T0+RL+BL: dqs_oe=1, dqs_t_out=0, dq_oe=0. IDLE (cmd_ready=1) at T0+RL+BL+1. If RL=2, WAIT is skipped.
- Write: WAIT through T0+WL-1 (skipped if WL=1). BURST T0+WL .. T0+WL+BL-1: each cycle sample dq_in into wr_line word (col+k) mod BL; wr_mask for that word = dm_n_in; if dqs_t_in == dqs_c_in, set strobe_err. No outputs enabled during writes. wr_mask cleared to 0 at accept of each write. DONE at T0+WL+BL: wr_done=1 for exactly one cycle. IDLE at T0+WL+BL+1.
- wr_line/wr_mask hold until the next write accept.
- strobe_err clears only on RST.
- Back-to-back: a new command is accepted in the first IDLE cycle; there is no overlap of bursts.

Test Plan:
- Reset: hold RST 2 cycles -> cmd_ready=1, dq_oe=0, dqs_oe=0, dqs_c_out=1, wr_done=0, strobe_err=0.
- Read, col=0, rd_line words 0x100+i: accept at T0 -> dqs_oe=1 with DQS low at T0+3; dq_out=0x100..0x107 at T0+4..T0+11; dqs_t_out toggles 1,0,...; POST at T0+12; cmd_ready=1 at T0+13.
- Read wrap, col=5 -> beat order words 5,6,7,0,1,2,3,4 (dq_out 0x105,0x106,0x107,0x100,...).
- Write, col=2, dq_in beats 0xA0..0xA7, dm_n_in low on beat 3, legal strobes -> wr_done at T0+10; wr_line word (2+k)%8 = 0xA0+k; wr_mask=8'b1101_1111 (word 5 masked); strobe_err=0.
- Write with dqs_t_in=dqs_c_in=1 on beat 4 -> strobe_err=1 and stays 1 through a following read; cmd_valid asserted during the burst is not accepted (cmd_ready=0).
- RST asserted at T0+6 of a read -> dq_oe=dqs_oe=0 next cycle; IDLE, cmd_ready=1; a following write completes normally.
